// File: rtl/alu_mc.sv
// alu_mc: WIDTH-bit ALU with the 16-code FunSel map and a packed ZCNO flag word.
// Shifts/rotates step one bit per cycle under a Start/Busy/Done handshake.
module alu_mc #(
    parameter int WIDTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Start,
    input  logic [3:0]               FunSel,
    input  logic [WIDTH-1:0]         A,
    input  logic [WIDTH-1:0]         B,
    input  logic [$clog2(WIDTH)-1:0] ShAmt,
    input  logic                     FlagWE,
    output logic [WIDTH-1:0]         OutALU,
    output logic [3:0]               ZCNO,
    output logic                     Busy,
    output logic                     Done
);

    localparam int SW  = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_CMP = 4'h6;
    localparam logic [3:0] OP_LSL = 4'hB;
    localparam logic [3:0] OP_LSR = 4'hC;
    localparam logic [3:0] OP_ASL = 4'hD;
    localparam logic [3:0] OP_ASR = 4'hE;
    localparam logic [3:0] OP_CSR = 4'hF;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] work;
    logic             sh_c;
    logic             sh_o;
    logic [SW-1:0]    rem;
    logic [3:0]       op_q;
    logic             we_q;

    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_o;
    logic             alu_wr;
    logic [3:0]       alu_flags;

    assign add_w = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, ZCNO[2]};
    assign sub_w = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        alu_res = A;
        alu_c   = ZCNO[2];
        alu_o   = ZCNO[0];
        alu_wr  = 1'b1;
        case (FunSel)
            4'h0: alu_res = A;
            4'h1: alu_res = B;
            4'h2: alu_res = ~A;
            4'h3: alu_res = ~B;
            OP_ADD: begin
                alu_res = add_w[MSB:0];
                alu_c   = add_w[WIDTH];
                alu_o   = (A[MSB] == B[MSB]) && (add_w[MSB] != A[MSB]);
            end
            OP_SUB, OP_CMP: begin
                alu_res = sub_w[MSB:0];
                alu_c   = sub_w[WIDTH];
                alu_o   = (A[MSB] != B[MSB]) && (sub_w[MSB] != A[MSB]);
                alu_wr  = (FunSel != OP_CMP);
            end
            4'h7: alu_res = A & B;
            4'h8: alu_res = A | B;
            4'h9: alu_res = ~(A & B);
            4'hA: alu_res = A ^ B;
            default: alu_res = A;
        endcase
        alu_flags = {alu_res == '0, alu_c, alu_res[MSB], alu_o};
    end

    // One shift step: returns {msb_changed, carry_out, result}.
    function automatic logic [WIDTH+1:0] step(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] r,
        input logic             c
    );
        logic [WIDTH-1:0] n;
        logic             co;
        logic             chg;
        n   = r;
        co  = c;
        chg = 1'b0;
        case (op)
            OP_LSL, OP_ASL: begin
                n   = {r[MSB-1:0], 1'b0};
                co  = r[MSB];
                chg = r[MSB] ^ r[MSB-1];
            end
            OP_LSR: begin
                n  = {1'b0, r[MSB:1]};
                co = r[0];
            end
            OP_ASR: begin
                n  = {r[MSB], r[MSB:1]};
                co = r[0];
            end
            OP_CSR: begin
                n  = {c, r[MSB:1]};
                co = r[0];
            end
            default: ;
        endcase
        return {chg, co, n};
    endfunction

    function automatic logic [3:0] sh_flags(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] res,
        input logic             co,
        input logic             o_acc,
        input logic             o_old
    );
        return {res == '0, co, res[MSB], (op == OP_ASL) ? o_acc : o_old};
    endfunction

    logic [WIDTH+1:0] st0;
    logic [WIDTH+1:0] stn;

    assign st0 = step(FunSel, A, ZCNO[2]);
    assign stn = step(op_q, work, sh_c);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            OutALU <= '0;
            ZCNO   <= '0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            work   <= '0;
            sh_c   <= 1'b0;
            sh_o   <= 1'b0;
            rem    <= '0;
            op_q   <= '0;
            we_q   <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        if (FunSel <= 4'hA) begin
                            if (alu_wr)
                                OutALU <= alu_res;
                            if (FlagWE)
                                ZCNO <= alu_flags;
                            Done <= 1'b1;
                        end else if (ShAmt == '0) begin
                            OutALU <= A;
                            if (FlagWE)
                                ZCNO <= {A == '0, ZCNO[2], A[MSB], ZCNO[0]};
                            Done <= 1'b1;
                        end else if (ShAmt == SW'(1)) begin
                            OutALU <= st0[MSB:0];
                            if (FlagWE)
                                ZCNO <= sh_flags(FunSel, st0[MSB:0], st0[WIDTH],
                                                 st0[WIDTH+1], ZCNO[0]);
                            Done <= 1'b1;
                        end else begin
                            work  <= st0[MSB:0];
                            sh_c  <= st0[WIDTH];
                            sh_o  <= st0[WIDTH+1];
                            rem   <= ShAmt - SW'(1);
                            op_q  <= FunSel;
                            we_q  <= FlagWE;
                            Busy  <= 1'b1;
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    // rem counts the steps still to do, including this one
                    if (rem == SW'(1)) begin
                        OutALU <= stn[MSB:0];
                        if (we_q)
                            ZCNO <= sh_flags(op_q, stn[MSB:0], stn[WIDTH],
                                             sh_o | stn[WIDTH+1], ZCNO[0]);
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        work <= stn[MSB:0];
                        sh_c <= stn[WIDTH];
                        sh_o <= sh_o | stn[WIDTH+1];
                        rem  <= rem - SW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
